// File: rtl/dsn_rom_reader.sv
// 1-Wire DSN reader: reset/presence, Read ROM (0x33), 64-bit ROM read and CRC-8 check on one channel.
// Latency: start-to-done = 1 + T_INIT + T_RREC + 72*T_SLOT + 1 clocks; shorter on abort.
// Handshake: level start; done held until start falls, so a held start never retriggers.
module dsn_rom_reader #(
    parameter int NCH     = 3,
    parameter int CHW     = 2,
    parameter int CNTW    = 16,
    parameter int T_INIT  = 36000,
    parameter int T_PRES  = 2800,
    parameter int T_RREC  = 20000,
    parameter int T_SLOT  = 4800,
    parameter int T_W0    = 4080,
    parameter int T_W1    = 64,
    parameter int T_RDLAT = 480
) (
    input  logic            clock,
    input  logic            global_reset,
    input  logic            start,
    input  logic [CHW-1:0]  ch_sel,
    input  logic [NCH-1:0]  dsn_in,
    output logic [NCH-1:0]  dsn_oe,
    output logic            busy,
    output logic            done,
    output logic            present,
    output logic            crc_ok,
    output logic [63:0]     dsn_data
);

    localparam logic [7:0] CMD_READ_ROM = 8'h33;
    localparam logic [7:0] CRC_POLY     = 8'h8C;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_PRES,
        S_WBIT,
        S_RBIT,
        S_CHECK,
        S_UNSTART
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CNTW-1:0] cnt;
    logic [5:0]      bit_idx;
    logic [CHW-1:0]  ch;
    logic [7:0]      crc;

    logic            cnt_clr;
    logic            bit_inc;
    logic            bit_clr;
    logic            drive;
    logic            line_in;
    logic            ch_sel_valid;
    logic            wr_bit;
    logic [CNTW-1:0] wr_low;
    logic            fb;
    logic [7:0]      crc_upd;

    logic            init_end;
    logic            pres_smp;
    logic            rrec_end;
    logic            slot_end;
    logic            rd_smp;

    assign init_end = (cnt == CNTW'(T_INIT - 1));
    assign pres_smp = (cnt == CNTW'(T_PRES));
    assign rrec_end = (cnt == CNTW'(T_RREC - 1));
    assign slot_end = (cnt == CNTW'(T_SLOT - 1));
    assign rd_smp   = (cnt == CNTW'(T_RDLAT));

    assign ch_sel_valid = (int'(ch_sel) < NCH);
    assign wr_bit       = CMD_READ_ROM[bit_idx[2:0]];
    assign wr_low       = wr_bit ? CNTW'(T_W1) : CNTW'(T_W0);

    // Level of the latched channel; an invalid channel reads as an idle (high) line.
    always_comb begin
        line_in = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (ch == CHW'(i)) begin
                line_in = dsn_in[i];
            end
        end
    end

    assign fb      = crc[0] ^ line_in;
    assign crc_upd = {1'b0, crc[7:1]} ^ (fb ? CRC_POLY : 8'h00);

    always_ff @(posedge clock or posedge global_reset) begin
        if (global_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        bit_inc   = 1'b0;
        bit_clr   = 1'b0;
        drive     = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_clr = 1'b1;
                bit_clr = 1'b1;
                if (start) begin
                    state_nxt = ch_sel_valid ? S_INIT : S_CHECK;
                end
            end
            S_INIT: begin
                drive = 1'b1;
                if (init_end) begin
                    cnt_clr   = 1'b1;
                    state_nxt = S_PRES;
                end
            end
            S_PRES: begin
                if (rrec_end) begin
                    cnt_clr   = 1'b1;
                    bit_clr   = 1'b1;
                    state_nxt = present ? S_WBIT : S_CHECK;
                end
            end
            S_WBIT: begin
                drive = (cnt < wr_low);
                if (slot_end) begin
                    cnt_clr = 1'b1;
                    if (bit_idx == 6'd7) begin
                        bit_clr   = 1'b1;
                        state_nxt = S_RBIT;
                    end else begin
                        bit_inc = 1'b1;
                    end
                end
            end
            S_RBIT: begin
                drive = (cnt < CNTW'(T_W1));
                if (slot_end) begin
                    cnt_clr = 1'b1;
                    if (bit_idx == 6'd63) begin
                        bit_clr   = 1'b1;
                        state_nxt = S_CHECK;
                    end else begin
                        bit_inc = 1'b1;
                    end
                end
            end
            S_CHECK: begin
                cnt_clr   = 1'b1;
                state_nxt = S_UNSTART;
            end
            S_UNSTART: begin
                cnt_clr = 1'b1;
                if (!start) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                cnt_clr   = 1'b1;
                bit_clr   = 1'b1;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Pin drive depends only on registered state, so async reset releases the pin immediately.
    always_comb begin
        dsn_oe = '0;
        for (int i = 0; i < NCH; i++) begin
            dsn_oe[i] = drive && (ch == CHW'(i));
        end
    end

    assign busy = (state != S_IDLE) && (state != S_UNSTART);
    assign done = (state == S_UNSTART);

    always_ff @(posedge clock or posedge global_reset) begin
        if (global_reset) begin
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            if (cnt_clr) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (bit_clr) begin
                bit_idx <= '0;
            end else if (bit_inc) begin
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge global_reset) begin
        if (global_reset) begin
            ch       <= '0;
            crc      <= '0;
            present  <= 1'b0;
            crc_ok   <= 1'b0;
            dsn_data <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                ch       <= ch_sel;
                crc      <= '0;
                present  <= 1'b0;
                crc_ok   <= 1'b0;
                dsn_data <= '0;
            end
            if (state == S_PRES && pres_smp) begin
                present <= ~line_in;
            end
            // ROM arrives LSB first: shifting right leaves the first bit in bit 0.
            if (state == S_RBIT && rd_smp) begin
                dsn_data <= {line_in, dsn_data[63:1]};
                crc      <= crc_upd;
            end
            if (state == S_CHECK) begin
                crc_ok <= present & (crc == 8'h00);
            end
        end
    end

endmodule

// File: tb/tb_dsn_rom_reader.sv
// Directed bench for dsn_rom_reader with shortened 1-Wire timing and a behavioural ROM slave.
module tb_dsn_rom_reader;

    localparam int T_INIT  = 360;
    localparam int T_PRES  = 28;
    localparam int T_RREC  = 200;
    localparam int T_SLOT  = 48;
    localparam int T_W0    = 40;
    localparam int T_W1    = 4;
    localparam int T_RDLAT = 12;
    localparam int FULL_CYC  = 1 + T_INIT + T_RREC + 72 * T_SLOT + 1;
    localparam int ABORT_CYC = 1 + T_INIT + T_RREC + 1;
    localparam logic [63:0] ROM     = 64'hA200_0000_01B8_1C02;
    localparam logic [63:0] FLIP20  = 64'h0000_0000_0010_0000;
    localparam logic [63:0] ROM_BAD = 64'hA200_0000_01A8_1C02;

    localparam int SL_IDLE = 0;
    localparam int SL_CMD  = 1;
    localparam int SL_READ = 2;

    logic        clock = 1'b0;
    logic        global_reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  ch_sel = 2'd0;
    logic [2:0]  dsn_in;
    logic [2:0]  dsn_oe;
    logic        busy;
    logic        done;
    logic        present;
    logic        crc_ok;
    logic [63:0] dsn_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    dsn_rom_reader #(
        .NCH(3), .CHW(2), .CNTW(16),
        .T_INIT(T_INIT), .T_PRES(T_PRES), .T_RREC(T_RREC), .T_SLOT(T_SLOT),
        .T_W0(T_W0), .T_W1(T_W1), .T_RDLAT(T_RDLAT)
    ) dut (
        .clock(clock), .global_reset(global_reset), .start(start), .ch_sel(ch_sel),
        .dsn_in(dsn_in), .dsn_oe(dsn_oe), .busy(busy), .done(done),
        .present(present), .crc_ok(crc_ok), .dsn_data(dsn_data)
    );

    // Slave configuration (written by tests) and state (written by slave process only)
    int          slave_ch = 1;
    logic        slave_en = 1'b1;
    logic [63:0] slave_rom = ROM;
    logic [63:0] slave_flip = 64'h0;
    int          sl_state = SL_IDLE;
    int          low_len = 0;
    int          pres_delay = 0;
    int          pull_timer = 0;
    logic        oe_prev = 1'b0;
    logic [7:0]  cmd_rx = 8'h00;
    int          cmd_bits = 0;
    int          rbit = 0;
    int          rst_count = 0;
    int          rst_len = 0;
    logic        slave_pull;

    assign slave_pull = (pull_timer > 0) && slave_en;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            dsn_in[i] = ~dsn_oe[i] & ~(slave_pull && (slave_ch == i));
        end
    end

    always @(posedge clock) begin : slave
        logic        oe_now;
        logic [63:0] rom_tx;
        oe_now = dsn_oe[slave_ch];
        rom_tx = slave_rom ^ slave_flip;
        if (pull_timer > 0) pull_timer <= pull_timer - 1;
        if (pres_delay > 0) begin
            pres_delay <= pres_delay - 1;
            if (pres_delay == 1) pull_timer <= 60;
        end
        if (oe_now && !oe_prev && sl_state == SL_READ) begin
            if (!rom_tx[rbit]) pull_timer <= 20;
            if (rbit == 63) sl_state <= SL_IDLE;
            rbit <= rbit + 1;
        end
        if (oe_now) begin
            low_len <= low_len + 1;
        end else if (oe_prev) begin
            low_len <= 0;
            if (low_len >= 300) begin
                rst_count  <= rst_count + 1;
                rst_len    <= low_len;
                sl_state   <= SL_CMD;
                cmd_bits   <= 0;
                cmd_rx     <= 8'h00;
                rbit       <= 0;
                pres_delay <= 10;
            end else if (sl_state == SL_CMD) begin
                cmd_rx <= {(low_len < 20), cmd_rx[7:1]};
                if (cmd_bits == 7) sl_state <= SL_READ;
                cmd_bits <= cmd_bits + 1;
            end
        end
        oe_prev <= oe_now;
    end

    // Pin activity monitors
    logic       seen_clr = 1'b0;
    logic [2:0] oe_seen = 3'b000;
    logic [2:0] oe_prev_all = 3'b000;
    int         pulse_cnt = 0;

    always @(posedge clock) begin
        if (seen_clr) oe_seen <= 3'b000;
        else          oe_seen <= oe_seen | dsn_oe;
        oe_prev_all <= dsn_oe;
        if (|(dsn_oe & ~oe_prev_all)) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic clear_seen();
        seen_clr = 1'b1;
        @(posedge clock); #1;
        seen_clr = 1'b0;
    endtask

    task automatic run_txn(input logic [1:0] sel, input bit scramble, output int cycles);
        @(negedge clock);
        ch_sel = sel;
        start  = 1'b1;
        cycles = 0;
        while (cycles < 6000) begin
            @(posedge clock); #1;
            cycles++;
            if (scramble && cycles == 5) ch_sel = ~sel;
            if (done) break;
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL txn_timeout: done=%b after %0d cycles, required 1", done, cycles);
        end
    endtask

    task automatic drop_start();
        @(negedge clock);
        start = 1'b0;
        @(posedge clock); #1;
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_after_drop: got %b, required 0", done);
        end
    endtask

    task automatic test_reset();
        global_reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if ({dsn_oe, busy, done, present, crc_ok} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: oe=%b busy=%b done=%b pres=%b crc=%b, required all 0",
                     dsn_oe, busy, done, present, crc_ok);
        end
        n_checks++;
        if (dsn_data !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h, required 0", dsn_data);
        end
        @(negedge clock);
        global_reset = 1'b0;
    endtask

    task automatic test_read_ok();
        int cyc;
        int p0;
        slave_ch = 1; slave_flip = 64'h0;
        clear_seen();
        p0 = pulse_cnt;
        run_txn(2'd1, 1'b1, cyc);
        n_checks++;
        if (cyc !== FULL_CYC) begin
            n_fail++; $display("FAIL ok_latency: got %0d cycles, required %0d", cyc, FULL_CYC);
        end
        n_checks++;
        if (dsn_data !== ROM) begin
            n_fail++; $display("FAIL ok_data: got %h, required %h", dsn_data, ROM);
        end
        n_checks++;
        if ({present, crc_ok, busy} !== 3'b110) begin
            n_fail++; $display("FAIL ok_flags: pres=%b crc=%b busy=%b, required 1 1 0", present, crc_ok, busy);
        end
        n_checks++;
        if (cmd_rx !== 8'h33) begin
            n_fail++; $display("FAIL ok_cmd: slave got %h, required 33", cmd_rx);
        end
        n_checks++;
        if (rst_len !== T_INIT) begin
            n_fail++; $display("FAIL ok_init_len: got %0d, required %0d", rst_len, T_INIT);
        end
        n_checks++;
        if (oe_seen !== 3'b010 || pulse_cnt - p0 !== 73) begin
            n_fail++; $display("FAIL ok_pins: seen=%b pulses=%0d, required 010 and 73", oe_seen, pulse_cnt - p0);
        end
        drop_start();
    endtask

    task automatic test_crc_bad();
        int cyc;
        slave_ch = 1; slave_flip = FLIP20;
        run_txn(2'd1, 1'b0, cyc);
        n_checks++;
        if (dsn_data !== ROM_BAD) begin
            n_fail++; $display("FAIL bad_data: got %h, required %h", dsn_data, ROM_BAD);
        end
        n_checks++;
        if ({present, crc_ok} !== 2'b10) begin
            n_fail++; $display("FAIL bad_flags: pres=%b crc=%b, required 1 0", present, crc_ok);
        end
        drop_start();
        slave_flip = 64'h0;
    endtask

    task automatic test_bad_ch();
        int cyc;
        clear_seen();
        run_txn(2'd3, 1'b0, cyc);
        n_checks++;
        if (cyc !== 2) begin
            n_fail++; $display("FAIL badch_latency: got %0d, required 2", cyc);
        end
        n_checks++;
        if ({oe_seen, present, crc_ok} !== 5'b0 || dsn_data !== 64'h0) begin
            n_fail++; $display("FAIL badch_state: seen=%b pres=%b crc=%b data=%h, required all 0",
                               oe_seen, present, crc_ok, dsn_data);
        end
        drop_start();
    endtask

    task automatic test_no_slave();
        int cyc;
        int p0;
        slave_ch = 1;
        clear_seen();
        p0 = pulse_cnt;
        run_txn(2'd0, 1'b0, cyc);
        n_checks++;
        if (cyc !== ABORT_CYC) begin
            n_fail++; $display("FAIL noslave_latency: got %0d, required %0d", cyc, ABORT_CYC);
        end
        n_checks++;
        if ({present, crc_ok} !== 2'b00 || dsn_data !== 64'h0) begin
            n_fail++; $display("FAIL noslave_result: pres=%b crc=%b data=%h, required 0 0 0", present, crc_ok, dsn_data);
        end
        n_checks++;
        if (oe_seen !== 3'b001 || pulse_cnt - p0 !== 1) begin
            n_fail++; $display("FAIL noslave_pins: seen=%b pulses=%0d, required 001 and 1", oe_seen, pulse_cnt - p0);
        end
        drop_start();
    endtask

    task automatic test_reset_mid();
        int cyc;
        int n;
        slave_ch = 1;
        @(negedge clock);
        ch_sel = 2'd1;
        start  = 1'b1;
        n = 0;
        while (n < 6000) begin
            @(posedge clock); #1;
            n++;
            if (sl_state == SL_READ && rbit == 31) break;
        end
        n_checks++;
        if (dsn_oe !== 3'b010) begin
            n_fail++; $display("FAIL mid_oe_before: got %b, required 010 (waited %0d)", dsn_oe, n);
        end
        global_reset = 1'b1;
        start = 1'b0;
        #1;
        n_checks++;
        if ({dsn_oe, busy, done, present, crc_ok} !== 7'b0 || dsn_data !== 64'h0) begin
            n_fail++; $display("FAIL mid_reset: oe=%b busy=%b done=%b pres=%b crc=%b data=%h, required all 0",
                               dsn_oe, busy, done, present, crc_ok, dsn_data);
        end
        @(negedge clock);
        @(negedge clock);
        global_reset = 1'b0;
        run_txn(2'd1, 1'b0, cyc);
        n_checks++;
        if (dsn_data !== ROM || {present, crc_ok} !== 2'b11 || cyc !== FULL_CYC) begin
            n_fail++; $display("FAIL mid_reread: data=%h pres=%b crc=%b cyc=%0d, required %h 1 1 %0d",
                               dsn_data, present, crc_ok, cyc, ROM, FULL_CYC);
        end
        drop_start();
    endtask

    task automatic test_back_to_back();
        int cyc;
        int r0;
        slave_ch = 1;
        r0 = rst_count;
        run_txn(2'd1, 1'b0, cyc);
        repeat (10000) @(posedge clock);
        #1;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL hold_done: done=%b busy=%b, required 1 0", done, busy);
        end
        n_checks++;
        if (rst_count - r0 !== 1) begin
            n_fail++; $display("FAIL hold_single: got %0d transactions, required 1", rst_count - r0);
        end
        drop_start();
        slave_ch = 2;
        clear_seen();
        run_txn(2'd2, 1'b0, cyc);
        n_checks++;
        if (dsn_data !== ROM || {present, crc_ok} !== 2'b11) begin
            n_fail++; $display("FAIL ch2_read: data=%h pres=%b crc=%b, required %h 1 1", dsn_data, present, crc_ok, ROM);
        end
        n_checks++;
        if (oe_seen !== 3'b100) begin
            n_fail++; $display("FAIL ch2_pins: seen=%b, required 100", oe_seen);
        end
        drop_start();
    endtask

    initial begin
        test_reset();
        test_read_ok();
        test_crc_bad();
        test_bad_ch();
        test_no_slave();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
